// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the default-slave state type for the splitter slice.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_t;

   typedef enum logic [1:0] {
      DS_IDLE = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } ds_state_t;

endpackage

// File: rtl/ahb_mssd_splitter_n_if.sv
// Master-side AHB bus plus the fanned-out slave bus handled by ahb_mssd_splitter_n.
interface ahb_mssd_splitter_n_if #(
   parameter int unsigned NSLV = 4,
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32
);
   logic [AW-1:0]      HADDR;
   logic [1:0]         HTRANS;
   logic               HWRITE;
   logic [2:0]         HSIZE;
   logic [2:0]         HBURST;
   logic [3:0]         HPROT;
   logic [3:0]         HMASTER;
   logic [DW-1:0]      HWDATA;
   logic               HMASTLOCK;
   logic [DW-1:0]      HRDATA_M;
   logic               HREADYOUT_M;
   logic [1:0]         HRESP_M;

   logic [NSLV-1:0]    HSEL_S;
   logic [AW-1:0]      HADDR_S;
   logic [1:0]         HTRANS_S;
   logic               HWRITE_S;
   logic [2:0]         HSIZE_S;
   logic [2:0]         HBURST_S;
   logic [3:0]         HPROT_S;
   logic [3:0]         HMASTER_S;
   logic [DW-1:0]      HWDATA_S;
   logic               HMASTLOCK_S;
   logic               HREADYIN_S;
   logic [NSLV*DW-1:0] HRDATA_S;
   logic [NSLV-1:0]    HREADYOUT_S;
   logic [2*NSLV-1:0]  HRESP_S;

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTER, HWDATA, HMASTLOCK,
      input  HRDATA_S, HREADYOUT_S, HRESP_S,
      output HRDATA_M, HREADYOUT_M, HRESP_M,
      output HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S,
      output HMASTER_S, HWDATA_S, HMASTLOCK_S, HREADYIN_S
   );

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTER, HWDATA, HMASTLOCK,
      output HRDATA_S, HREADYOUT_S, HRESP_S,
      input  HRDATA_M, HREADYOUT_M, HRESP_M,
      input  HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S,
      input  HMASTER_S, HWDATA_S, HMASTLOCK_S, HREADYIN_S
   );
endinterface

// File: rtl/ahb_mssd_default_slave.sv
// Internal default slave: two-cycle ERROR for unmapped active transfers, OKAY otherwise.
module ahb_mssd_default_slave
   import ahb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sel,
   input  logic       active,
   input  logic       hready,
   output logic       hreadyout,
   output logic [1:0] hresp,
   output logic       err_pulse
);
   ds_state_t state;
   logic      accept;

   // HREADY is low throughout DS_ERR1 when this slave owns the data phase,
   // so acceptance needs no state qualification.
   assign accept    = sel & active & hready;
   assign err_pulse = accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= DS_IDLE;
         hreadyout <= 1'b1;
         hresp     <= HRESP_OKAY;
      end else begin
         case (state)
            DS_IDLE: begin
               if (accept) begin
                  state     <= DS_ERR1;
                  hreadyout <= 1'b0;
                  hresp     <= HRESP_ERROR;
               end
            end
            DS_ERR1: begin
               state     <= DS_ERR2;
               hreadyout <= 1'b1;
               hresp     <= HRESP_ERROR;
            end
            DS_ERR2: begin
               if (accept) begin
                  state     <= DS_ERR1;
                  hreadyout <= 1'b0;
                  hresp     <= HRESP_ERROR;
               end else begin
                  state     <= DS_IDLE;
                  hreadyout <= 1'b1;
                  hresp     <= HRESP_OKAY;
               end
            end
            default: begin
               state     <= DS_IDLE;
               hreadyout <= 1'b1;
               hresp     <= HRESP_OKAY;
            end
         endcase
      end
   end
endmodule

// File: rtl/ahb_mssd_splitter_n.sv
// Master-side AHB decoder/mux: address-mapped slave selection, registered response
// select, internal default slave and saturating decode-error counter.
module ahb_mssd_splitter_n
   import ahb_pkg::*;
#(
   parameter int unsigned     NSLV     = 4,
   parameter int unsigned     AW       = 32,
   parameter int unsigned     DW       = 32,
   parameter logic [1:0]      MSEL_ID  = 2'b01,
   parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NSLV*AW-1:0] SLV_MASK = {4{32'hF000_0000}},
   parameter int unsigned     ECW      = 8
) (
   input  logic           HCLK,
   input  logic           HRESETn,
   input  logic [1:0]     hmsel,
   ahb_mssd_splitter_n_if.slave bus,
   input  logic           err_clr,
   output logic [ECW-1:0] err_cnt
);
   logic            en;
   logic [NSLV-1:0] hsel;
   logic            def_sel;
   logic            found;
   logic [NSLV:0]   dsel;
   logic            active;
   logic            hready_m;
   logic [DW-1:0]   rdata_m;
   logic [1:0]      resp_m;
   logic            ds_ready;
   logic [1:0]      ds_resp;
   logic            err_pulse;

   assign en = (hmsel == MSEL_ID);

   // Write data is never gated so a data phase still in flight after hmsel moves completes.
   assign bus.HADDR_S     = en ? bus.HADDR     : '0;
   assign bus.HTRANS_S    = en ? bus.HTRANS    : HTRANS_IDLE;
   assign bus.HWRITE_S    = en ? bus.HWRITE    : 1'b0;
   assign bus.HSIZE_S     = en ? bus.HSIZE     : '0;
   assign bus.HBURST_S    = en ? bus.HBURST    : '0;
   assign bus.HPROT_S     = en ? bus.HPROT     : '0;
   assign bus.HMASTER_S   = en ? bus.HMASTER   : '0;
   assign bus.HMASTLOCK_S = en ? bus.HMASTLOCK : 1'b0;
   assign bus.HWDATA_S    = bus.HWDATA;
   assign bus.HSEL_S      = hsel;
   assign bus.HREADYIN_S  = hready_m;

   always_comb begin
      hsel  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (!found && en &&
             ((bus.HADDR & SLV_MASK[i*AW +: AW]) == (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))) begin
            hsel[i] = 1'b1;
            found   = 1'b1;
         end
      end
      def_sel = en & ~found;
   end

   assign active = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dsel <= '0;
      end else if (hready_m) begin
         dsel <= {def_sel, hsel};
      end
   end

   always_comb begin
      rdata_m  = '0;
      hready_m = 1'b1;
      resp_m   = HRESP_OKAY;
      if (dsel[NSLV]) begin
         hready_m = ds_ready;
         resp_m   = ds_resp;
      end
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (dsel[i]) begin
            rdata_m  = bus.HRDATA_S[i*DW +: DW];
            hready_m = bus.HREADYOUT_S[i];
            resp_m   = bus.HRESP_S[2*i +: 2];
         end
      end
   end

   assign bus.HRDATA_M    = rdata_m;
   assign bus.HREADYOUT_M = hready_m;
   assign bus.HRESP_M     = resp_m;

   ahb_mssd_default_slave u_default (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .sel       (def_sel),
      .active    (active),
      .hready    (hready_m),
      .hreadyout (ds_ready),
      .hresp     (ds_resp),
      .err_pulse (err_pulse)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err_cnt <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
      end else if (err_pulse && (err_cnt != '1)) begin
         err_cnt <= err_cnt + ECW'(1);
      end
   end
endmodule

// File: tb/tb_ahb_mssd_splitter_n.sv
// Directed bench for ahb_mssd_splitter_n: decode, response mux, default slave, error count.
module tb_ahb_mssd_splitter_n;
   import ahb_pkg::*;

   logic       HCLK;
   logic       HRESETn;
   logic [1:0] hmsel;
   logic [1:0] hmsel2;
   logic       err_clr;
   logic [7:0] err_cnt;
   logic [7:0] err_cnt2;
   int         errors;
   int         checks;

   ahb_mssd_splitter_n_if #(.NSLV(4), .AW(32), .DW(32)) b  ();
   ahb_mssd_splitter_n_if #(.NSLV(4), .AW(32), .DW(32)) b2 ();

   ahb_mssd_splitter_n #(.NSLV(4), .AW(32), .DW(32), .MSEL_ID(2'b01), .ECW(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .hmsel(hmsel), .bus(b.slave),
      .err_clr(err_clr), .err_cnt(err_cnt)
   );

   ahb_mssd_splitter_n #(
      .NSLV(4), .AW(32), .DW(32), .MSEL_ID(2'b01), .ECW(8),
      .SLV_BASE({32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000}),
      .SLV_MASK({4{32'hF000_0000}})
   ) dut2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .hmsel(hmsel2), .bus(b2.slave),
      .err_clr(1'b0), .err_cnt(err_cnt2)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic clk_step;
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset;
      HRESETn = 1'b0; hmsel = 2'b01; hmsel2 = 2'b01; err_clr = 1'b0;
      b.HADDR = 32'h1000_0000; b.HTRANS = HTRANS_IDLE; b.HWRITE = 1'b0; b.HSIZE = 3'b010;
      b.HBURST = 3'b000; b.HPROT = 4'h3; b.HMASTER = 4'h1; b.HWDATA = 32'h0; b.HMASTLOCK = 1'b0;
      b.HRDATA_S = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
      b.HREADYOUT_S = 4'hF; b.HRESP_S = 8'h00;
      b2.HADDR = 32'h0; b2.HTRANS = HTRANS_IDLE; b2.HWRITE = 1'b0; b2.HSIZE = 3'b010;
      b2.HBURST = 3'b000; b2.HPROT = 4'h3; b2.HMASTER = 4'h2; b2.HWDATA = 32'h0; b2.HMASTLOCK = 1'b0;
      b2.HRDATA_S = '0; b2.HREADYOUT_S = 4'hF; b2.HRESP_S = 8'h00;
      #2;
      checks++; if (b.HREADYOUT_M !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", b.HREADYOUT_M); end
      checks++; if (b.HRESP_M !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b expected 00", b.HRESP_M); end
      checks++; if (b.HRDATA_M !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", b.HRDATA_M); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", err_cnt); end
      checks++; if (b.HSEL_S !== 4'b0010) begin errors++; $display("FAIL reset_hsel: got %b expected 0010", b.HSEL_S); end
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      clk_step();
   endtask

   task automatic test_read;
      b.HADDR = 32'h2000_0010; b.HTRANS = HTRANS_NONSEQ; b.HWRITE = 1'b0;
      b.HRDATA_S[64 +: 32] = 32'hA5A5_5A5A;
      #1;
      checks++; if (b.HSEL_S !== 4'b0100) begin errors++; $display("FAIL read_hsel: got %b expected 0100", b.HSEL_S); end
      checks++; if (b.HTRANS_S !== 2'b10) begin errors++; $display("FAIL read_htrans_s: got %b expected 10", b.HTRANS_S); end
      checks++; if (b.HADDR_S !== 32'h2000_0010) begin errors++; $display("FAIL read_haddr_s: got %h expected 20000010", b.HADDR_S); end
      clk_step();
      b.HTRANS = HTRANS_IDLE;
      #1;
      checks++; if (b.HRDATA_M !== 32'hA5A5_5A5A) begin errors++; $display("FAIL read_rdata: got %h expected a5a55a5a", b.HRDATA_M); end
      checks++; if (b.HRESP_M !== 2'b00) begin errors++; $display("FAIL read_resp: got %b expected 00", b.HRESP_M); end
      checks++; if (b.HREADYOUT_M !== 1'b1) begin errors++; $display("FAIL read_ready: got %b expected 1", b.HREADYOUT_M); end
      clk_step();
   endtask

   task automatic test_default_error;
      b.HADDR = 32'h8000_0000; b.HTRANS = HTRANS_BUSY;
      #1;
      checks++; if (b.HSEL_S !== 4'b0000) begin errors++; $display("FAIL unmapped_hsel: got %b expected 0000", b.HSEL_S); end
      clk_step();
      b.HTRANS = HTRANS_NONSEQ;
      #1;
      checks++; if (b.HREADYOUT_M !== 1'b1) begin errors++; $display("FAIL busy_ready: got %b expected 1", b.HREADYOUT_M); end
      checks++; if (b.HRESP_M !== 2'b00) begin errors++; $display("FAIL busy_resp: got %b expected 00", b.HRESP_M); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL busy_errcnt: got %0d expected 0", err_cnt); end
      clk_step();
      b.HTRANS = HTRANS_IDLE;
      #1;
      checks++; if (b.HREADYOUT_M !== 1'b0) begin errors++; $display("FAIL err1_ready: got %b expected 0", b.HREADYOUT_M); end
      checks++; if (b.HRESP_M !== 2'b01) begin errors++; $display("FAIL err1_resp: got %b expected 01", b.HRESP_M); end
      checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err1_errcnt: got %0d expected 1", err_cnt); end
      clk_step();
      #1;
      checks++; if (b.HREADYOUT_M !== 1'b1) begin errors++; $display("FAIL err2_ready: got %b expected 1", b.HREADYOUT_M); end
      checks++; if (b.HRESP_M !== 2'b01) begin errors++; $display("FAIL err2_resp: got %b expected 01", b.HRESP_M); end
      clk_step();
      #1;
      checks++; if (b.HRESP_M !== 2'b00) begin errors++; $display("FAIL post_err_resp: got %b expected 00", b.HRESP_M); end
      checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL post_err_errcnt: got %0d expected 1", err_cnt); end
   endtask

   task automatic test_saturation;
      b.HADDR = 32'h8000_0000; b.HTRANS = HTRANS_NONSEQ;
      // 600 edges accept 300 back-to-back errors; the count starts at 1 and must stop at 255
      repeat (600) @(posedge HCLK);
      #1;
      checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_errcnt: got %0d expected 255", err_cnt); end
      checks++; if (b.HRESP_M !== 2'b01) begin errors++; $display("FAIL sat_resp: got %b expected 01", b.HRESP_M); end
      err_clr = 1'b1;
      clk_step();
      err_clr = 1'b0; b.HTRANS = HTRANS_IDLE;
      #1;
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_vs_inc_errcnt: got %0d expected 0", err_cnt); end
      checks++; if (b.HREADYOUT_M !== 1'b0) begin errors++; $display("FAIL clr_err1_ready: got %b expected 0", b.HREADYOUT_M); end
      clk_step();
      clk_step();
   endtask

   task automatic test_wait_hmsel;
      hmsel = 2'b01; b.HADDR = 32'h1000_0004; b.HTRANS = HTRANS_NONSEQ;
      #1;
      checks++; if (b.HSEL_S !== 4'b0010) begin errors++; $display("FAIL wait_hsel: got %b expected 0010", b.HSEL_S); end
      clk_step();
      hmsel = 2'b10; b.HREADYOUT_S[1] = 1'b0; b.HRDATA_S[32 +: 32] = 32'h1111_0001;
      b.HADDR = 32'h1000_0008; b.HWDATA = 32'hDEAD_BEEF;
      #1;
      checks++; if (b.HREADYOUT_M !== 1'b0) begin errors++; $display("FAIL wait1_ready: got %b expected 0", b.HREADYOUT_M); end
      checks++; if (b.HRDATA_M !== 32'h1111_0001) begin errors++; $display("FAIL wait1_rdata: got %h expected 11110001", b.HRDATA_M); end
      checks++; if (b.HSEL_S !== 4'b0000) begin errors++; $display("FAIL wait1_hsel_gated: got %b expected 0000", b.HSEL_S); end
      checks++; if (b.HTRANS_S !== 2'b00) begin errors++; $display("FAIL wait1_htrans_gated: got %b expected 00", b.HTRANS_S); end
      checks++; if (b.HWDATA_S !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait1_hwdata_pass: got %h expected deadbeef", b.HWDATA_S); end
      checks++; if (b.HREADYIN_S !== 1'b0) begin errors++; $display("FAIL wait1_readyin: got %b expected 0", b.HREADYIN_S); end
      clk_step();
      b.HRDATA_S[32 +: 32] = 32'h1111_0002;
      #1;
      checks++; if (b.HRDATA_M !== 32'h1111_0002) begin errors++; $display("FAIL wait2_rdata: got %h expected 11110002", b.HRDATA_M); end
      checks++; if (b.HREADYOUT_M !== 1'b0) begin errors++; $display("FAIL wait2_ready: got %b expected 0", b.HREADYOUT_M); end
      clk_step();
      clk_step();
      b.HREADYOUT_S[1] = 1'b1; b.HRDATA_S[32 +: 32] = 32'h1111_00FF;
      #1;
      checks++; if (b.HRDATA_M !== 32'h1111_00FF) begin errors++; $display("FAIL wait_done_rdata: got %h expected 111100ff", b.HRDATA_M); end
      checks++; if (b.HREADYOUT_M !== 1'b1) begin errors++; $display("FAIL wait_done_ready: got %b expected 1", b.HREADYOUT_M); end
      clk_step();
      #1;
      checks++; if (b.HRDATA_M !== 32'h0) begin errors++; $display("FAIL after_switch_rdata: got %h expected 0", b.HRDATA_M); end
      checks++; if (b.HREADYOUT_M !== 1'b1) begin errors++; $display("FAIL after_switch_ready: got %b expected 1", b.HREADYOUT_M); end
      checks++; if (b.HSEL_S !== 4'b0000) begin errors++; $display("FAIL after_switch_hsel: got %b expected 0000", b.HSEL_S); end
      checks++; if (b.HTRANS_S !== 2'b00) begin errors++; $display("FAIL after_switch_htrans: got %b expected 00", b.HTRANS_S); end
   endtask

   task automatic test_overlap;
      b2.HADDR = 32'h1000_0040;
      #1;
      checks++; if (b2.HSEL_S !== 4'b0001) begin errors++; $display("FAIL overlap_hsel: got %b expected 0001", b2.HSEL_S); end
      b2.HADDR = 32'h2000_0000;
      #1;
      checks++; if (b2.HSEL_S !== 4'b0100) begin errors++; $display("FAIL overlap_s2_hsel: got %b expected 0100", b2.HSEL_S); end
      b2.HADDR = 32'h4ABC_0000;
      #1;
      checks++; if (b2.HSEL_S !== 4'b1000) begin errors++; $display("FAIL overlap_s3_hsel: got %b expected 1000", b2.HSEL_S); end
   endtask

   task automatic test_reset_mid_error;
      hmsel = 2'b01; b.HADDR = 32'h8000_0000; b.HTRANS = HTRANS_NONSEQ;
      clk_step();
      b.HTRANS = HTRANS_IDLE;
      #1;
      checks++; if (b.HREADYOUT_M !== 1'b0) begin errors++; $display("FAIL rst_pre_ready: got %b expected 0", b.HREADYOUT_M); end
      checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL rst_pre_errcnt: got %0d expected 1", err_cnt); end
      #1;
      HRESETn = 1'b0;
      #1;
      checks++; if (b.HREADYOUT_M !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", b.HREADYOUT_M); end
      checks++; if (b.HRESP_M !== 2'b00) begin errors++; $display("FAIL rst_mid_resp: got %b expected 00", b.HRESP_M); end
      checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_errcnt: got %0d expected 0", err_cnt); end
      @(negedge HCLK);
      HRESETn = 1'b1;
      clk_step();
      checks++; if (b.HRESP_M !== 2'b00) begin errors++; $display("FAIL rst_post_resp: got %b expected 00", b.HRESP_M); end
      checks++; if (b.HREADYOUT_M !== 1'b1) begin errors++; $display("FAIL rst_post_ready: got %b expected 1", b.HREADYOUT_M); end
      b.HTRANS = HTRANS_NONSEQ;
      clk_step();
      b.HTRANS = HTRANS_IDLE;
      #1;
      checks++; if (b.HREADYOUT_M !== 1'b0) begin errors++; $display("FAIL rst_new_err1_ready: got %b expected 0", b.HREADYOUT_M); end
      checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL rst_new_errcnt: got %0d expected 1", err_cnt); end
      clk_step();
      clk_step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_read();
      test_default_error();
      test_saturation();
      test_wait_hmsel();
      test_overlap();
      test_reset_mid_error();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
